obj_fb_write_scheduler: RTL

- Sequences frame-buffer writes for the single 8x8 moving object during vertical blanking.
- Each frame, it erases the object at its previous position, then draws it at the new position.
- It writes the packed 1bpp frame buffer: 640x480, 8 pixels per byte, 80 bytes per line.
- It shares the FB write port with other writers through a request/grant handshake and never writes during active video.

---
 rtl/obj_fb_write_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/obj_fb_write_scheduler.sv
// Vertical-blanking frame-buffer writer for one 8x8 object: erases the previous
// position, then draws the new one, through a request/grant write port.
module obj_fb_write_scheduler #(
  parameter int         H_BYTES    = 80,
  parameter int         V_LINES    = 480,
  parameter int         OBJ_H      = 8,
  parameter logic [7:0] DRAW_DATA  = 8'hFF,
  parameter logic [7:0] ERASE_DATA = 8'h00
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        VBLANK,
  input  logic [9:0]  OBJ_X,
  input  logic [9:0]  OBJ_Y,
  input  logic        FB_WR_GNT,
  output logic        FB_WR_EN,
  output logic [15:0] FB_WR_ADDR,
  output logic [7:0]  FB_WR_DATA,
  output logic        BUSY,
  output logic        FRAME_DONE
);

  localparam int ROW_W = (OBJ_H > 1) ? $clog2(OBJ_H) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [15:0]        addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic               wr_en_q, wr_en_d;
  logic               vblank_q;
  logic [6:0]         xb_q, xb_d, old_xb_q, old_xb_d;
  logic [9:0]         yl_q, yl_d, old_yl_q, old_yl_d;
  logic [15:0]        draw_base_q, draw_base_d, old_base_q, old_base_d;
  logic               have_old_q, have_old_d;

  logic               rise, accept, last_row;
  logic [6:0]         xb_c;
  logic [9:0]         yl_c;
  logic [15:0]        base_c;
  logic               unused_x_lsbs;

  assign unused_x_lsbs = ^OBJ_X[2:0];

  always_comb begin
    rise     = VBLANK && !vblank_q;
    accept   = wr_en_q && FB_WR_GNT;
    last_row = (row_q == ROW_W'(OBJ_H - 1));
    xb_c     = (OBJ_X[9:3] > 7'(H_BYTES - 1)) ? 7'(H_BYTES - 1) : OBJ_X[9:3];
    yl_c     = (OBJ_Y > 10'(V_LINES - OBJ_H)) ? 10'(V_LINES - OBJ_H) : OBJ_Y;
    base_c   = 16'(yl_c) * 16'(H_BYTES) + 16'(xb_c);
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_en_d     = wr_en_q;
    xb_d        = xb_q;
    yl_d        = yl_q;
    draw_base_d = draw_base_q;
    old_xb_d    = old_xb_q;
    old_yl_d    = old_yl_q;
    old_base_d  = old_base_q;
    have_old_d  = have_old_q;

    case (state_q)
      S_IDLE: begin
        wr_en_d = 1'b0;
        if (rise) begin
          xb_d        = xb_c;
          yl_d        = yl_c;
          draw_base_d = base_c;
          row_d       = '0;
          wr_en_d     = 1'b1;
          if (have_old_q && (xb_c != old_xb_q || yl_c != old_yl_q)) begin
            state_d = S_ERASE;
            addr_d  = old_base_q;
            data_d  = ERASE_DATA;
          end else begin
            state_d = S_DRAW;
            addr_d  = base_c;
            data_d  = DRAW_DATA;
          end
        end
      end
      // Request tracks VBLANK so a blanking gap pauses without losing position.
      S_ERASE: begin
        wr_en_d = VBLANK;
        if (accept) begin
          if (last_row) begin
            state_d = S_DRAW;
            row_d   = '0;
            addr_d  = draw_base_q;
            data_d  = DRAW_DATA;
          end else begin
            row_d  = row_q + 1'b1;
            addr_d = addr_q + 16'(H_BYTES);
          end
        end
      end
      S_DRAW: begin
        wr_en_d = VBLANK;
        if (accept) begin
          if (last_row) begin
            state_d    = S_DONE;
            wr_en_d    = 1'b0;
            old_xb_d   = xb_q;
            old_yl_d   = yl_q;
            old_base_d = draw_base_q;
            have_old_d = 1'b1;
          end else begin
            row_d  = row_q + 1'b1;
            addr_d = addr_q + 16'(H_BYTES);
          end
        end
      end
      default: begin
        wr_en_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      vblank_q    <= 1'b0;
      xb_q        <= '0;
      yl_q        <= '0;
      draw_base_q <= '0;
      old_xb_q    <= '0;
      old_yl_q    <= '0;
      old_base_q  <= '0;
      have_old_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_en_q     <= wr_en_d;
      vblank_q    <= VBLANK;
      xb_q        <= xb_d;
      yl_q        <= yl_d;
      draw_base_q <= draw_base_d;
      old_xb_q    <= old_xb_d;
      old_yl_q    <= old_yl_d;
      old_base_q  <= old_base_d;
      have_old_q  <= have_old_d;
    end
  end

  assign FB_WR_EN   = wr_en_q;
  assign FB_WR_ADDR = addr_q;
  assign FB_WR_DATA = data_q;
  assign BUSY       = (state_q != S_IDLE);
  assign FRAME_DONE = (state_q == S_DONE);

endmodule
